// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters with a per-owner hold limit.
// Grants are registered; a long-running owner is preempted once it has held for MAX_HOLD cycles while others wait.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           preempted
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HMAX = HCW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic           pre_q, pre_d;

    logic [N-1:0]   ownerMask;
    logic [N-1:0]   cand;
    logic           winFound;
    logic [IDW-1:0] winIdx;

    // The current owner is excluded so a preempt always hands the grant to someone else.
    always_comb begin
        int idx;
        ownerMask = '0;
        if (state_q == OWNED) begin
            ownerMask[id_q] = 1'b1;
        end
        cand     = request & ~ownerMask;
        winFound = 1'b0;
        winIdx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!winFound && cand[idx]) begin
                winFound = 1'b1;
                winIdx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        pre_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (winFound) begin
                    state_d         = OWNED;
                    grant_d         = '0;
                    grant_d[winIdx] = 1'b1;
                    valid_d         = 1'b1;
                    id_d            = winIdx;
                    hcnt_d          = HCW'(1);
                    ptr_d           = IDW'((int'(winIdx) + 1) % N);
                end
            end
            OWNED: begin
                if (!request[id_q]) begin
                    if (winFound) begin
                        grant_d         = '0;
                        grant_d[winIdx] = 1'b1;
                        id_d            = winIdx;
                        hcnt_d          = HCW'(1);
                        ptr_d           = IDW'((int'(winIdx) + 1) % N);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        id_d    = '0;
                        hcnt_d  = '0;
                    end
                end else if (MAX_HOLD == 0 || hcnt_q < HMAX) begin
                    hcnt_d = (MAX_HOLD == 0) ? hcnt_q : hcnt_q + HCW'(1);
                end else if (winFound) begin
                    grant_d         = '0;
                    grant_d[winIdx] = 1'b1;
                    id_d            = winIdx;
                    hcnt_d          = HCW'(1);
                    ptr_d           = IDW'((int'(winIdx) + 1) % N);
                    pre_d           = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            pre_q   <= pre_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign preempted   = pre_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n (N=4, MAX_HOLD=4): a rule-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_rr_arbiter_n;

    localparam int NREQ = 4;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempted;

    int vectors = 0;
    int errors  = 0;
    bit checkEn = 1'b0;

    int mOwner = -1;
    int mPtr   = 0;
    int mHold  = 0;
    bit mPre   = 1'b0;

    rr_arbiter_n #(.N(NREQ), .MAX_HOLD(MAXH)) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .preempted(preempted)
    );

    always #5 clk = ~clk;

    // Round-robin pick: first set bit scanning from p upward with wrap, skipping one index.
    function automatic int pick(logic [3:0] r, int p, int excl);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    // Reference model: ownership, pointer and hold time tracked as plain integers.
    always @(posedge clk) begin
        int w;
        if (reset) begin
            mOwner = -1;
            mPtr   = 0;
            mHold  = 0;
            mPre   = 1'b0;
        end else begin
            mPre = 1'b0;
            if (mOwner < 0 || !request[mOwner]) begin
                w = pick(request, mPtr, -1);
                if (w >= 0) begin
                    mOwner = w;
                    mHold  = 1;
                    mPtr   = (w + 1) % NREQ;
                end else begin
                    mOwner = -1;
                    mHold  = 0;
                end
            end else if (mHold < MAXH) begin
                mHold = mHold + 1;
            end else begin
                w = pick(request, mPtr, mOwner);
                if (w >= 0) begin
                    mOwner = w;
                    mHold  = 1;
                    mPtr   = (w + 1) % NREQ;
                    mPre   = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-period.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.grant", int'(grant), (mOwner < 0) ? 0 : (1 << mOwner));
            checkOutput("model.grant_valid", int'(grant_valid), (mOwner < 0) ? 0 : 1);
            checkOutput("model.grant_id", int'(grant_id), (mOwner < 0) ? 0 : mOwner);
            checkOutput("model.preempted", int'(preempted), int'(mPre));
        end
    end

    task automatic applyStimulus(input logic [3:0] req, input int cycles);
        request = req;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        request = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] mixVec [8] = '{4'b0101, 4'b0101, 4'b0110, 4'b1110,
                               4'b1010, 4'b0011, 4'b0000, 4'b1001};

    initial begin
        reset   = 1'b1;
        request = 4'b0000;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset.grant", int'(grant), 0);
        checkOutput("reset.grant_id", int'(grant_id), 0);
        checkOutput("reset.preempted", int'(preempted), 0);
        reset = 1'b0;

        applyStimulus(4'b0000, 5);
        checkOutput("idle.grant", int'(grant), 0);
        checkOutput("idle.valid", int'(grant_valid), 0);

        applyStimulus(4'b1111, 1);
        checkOutput("all.first", int'(grant), 'b0001);
        applyStimulus(4'b1111, 3);
        checkOutput("all.hold4", int'(grant), 'b0001);
        applyStimulus(4'b1111, 1);
        checkOutput("all.xfer1", int'(grant), 'b0010);
        checkOutput("all.pre1", int'(preempted), 1);
        applyStimulus(4'b1111, 1);
        checkOutput("all.pre1_pulse", int'(preempted), 0);
        applyStimulus(4'b1111, 3);
        checkOutput("all.xfer2", int'(grant), 'b0100);
        applyStimulus(4'b1111, 4);
        checkOutput("all.xfer3", int'(grant), 'b1000);
        checkOutput("all.id3", int'(grant_id), 3);
        applyStimulus(4'b1111, 4);
        checkOutput("all.wrap", int'(grant), 'b0001);
        checkOutput("all.wrap_pre", int'(preempted), 1);
        applyStimulus(4'b0000, 1);
        checkOutput("all.release", int'(grant), 0);

        doReset();
        applyStimulus(4'b0011, 2);
        checkOutput("rel.owner0", int'(grant), 'b0001);
        applyStimulus(4'b0010, 1);
        checkOutput("rel.handoff", int'(grant), 'b0010);
        checkOutput("rel.valid", int'(grant_valid), 1);
        checkOutput("rel.nopre", int'(preempted), 0);

        doReset();
        applyStimulus(4'b0100, 10);
        checkOutput("solo.grant", int'(grant), 'b0100);
        checkOutput("solo.nopre", int'(preempted), 0);
        applyStimulus(4'b0000, 1);
        checkOutput("solo.drop", int'(grant), 0);

        doReset();
        applyStimulus(4'b1000, 2);
        applyStimulus(4'b1001, 1);
        checkOutput("wrap.owner3", int'(grant), 'b1000);
        applyStimulus(4'b0001, 1);
        checkOutput("wrap.grant0", int'(grant), 'b0001);
        checkOutput("wrap.id0", int'(grant_id), 0);
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b0011, 1);
        checkOutput("wrap.ptr1", int'(grant), 'b0010);

        doReset();
        applyStimulus(4'b0100, 2);
        checkOutput("rst.before", int'(grant), 'b0100);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.drop", int'(grant), 0);
        reset = 1'b0;
        applyStimulus(4'b1111, 1);
        checkOutput("rst.resume", int'(grant), 'b0001);

        foreach (mixVec[i]) begin
            applyStimulus(mixVec[i], 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
